// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains sync_fifo into a valid/ready stream.
// 2-entry skid buffer hides the FIFO read latency; m_last marks bursts.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  flush,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  words_out
);

   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

   typedef enum logic {S_RUN, S_FLUSH} state_t;

   state_t                r_state, w_state_nx;
   logic [1:0]            r_occ, w_occ_nx;
   logic                  r_inflight, w_inflight_nx;
   logic [DATA_WIDTH-1:0] r_b0, r_b1, w_b0_nx, w_b1_nx;
   logic [BW-1:0]         r_bcnt, w_bcnt_nx;
   logic                  r_valid, w_valid_nx;
   logic                  r_last, w_last_nx;
   logic                  r_busy, w_busy_nx;
   logic [CNT_WIDTH-1:0]  r_words, w_words_nx;
   logic                  w_pop, w_cap, w_rd;
   logic [2:0]            w_fill;

   assign fifo_rd_en = w_rd;
   assign m_valid    = r_valid;
   assign m_data     = r_b0;
   assign m_last     = r_last;
   assign busy       = r_busy;
   assign words_out  = r_words;

   // Next-state: read issue, buffer head/tail moves, burst count, flush FSM
   always_comb begin
      w_state_nx = r_state;
      w_occ_nx   = r_occ;
      w_b0_nx    = r_b0;
      w_b1_nx    = r_b1;
      w_bcnt_nx  = r_bcnt;
      w_words_nx = r_words;
      w_cap      = 1'b0;
      w_rd       = 1'b0;
      w_pop      = r_valid & m_ready;
      w_fill     = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
      if (w_pop)
         w_words_nx = r_words + CNT_WIDTH'(1);
      unique case (r_state)
         S_RUN: begin
            w_rd = enable & ~flush & ~fifo_empty & (w_fill < 3'd2);
            if (flush) begin
               w_state_nx = S_FLUSH;
               w_occ_nx   = 2'd0;
               w_bcnt_nx  = '0;
            end else begin
               w_cap = r_inflight;
               if (w_pop)
                  w_bcnt_nx = (r_bcnt == LAST) ? '0 : r_bcnt + BW'(1);
               unique case ({w_pop, w_cap})
                  2'b11: begin
                     if (r_occ == 2'd2) begin
                        w_b0_nx = r_b1;
                        w_b1_nx = fifo_rd_data;
                     end else begin
                        w_b0_nx = fifo_rd_data;
                     end
                  end
                  2'b10: begin
                     w_b0_nx  = r_b1;
                     w_occ_nx = r_occ - 2'd1;
                  end
                  2'b01: begin
                     if (r_occ == 2'd0)
                        w_b0_nx = fifo_rd_data;
                     else
                        w_b1_nx = fifo_rd_data;
                     w_occ_nx = r_occ + 2'd1;
                  end
                  default: ;
               endcase
            end
         end
         S_FLUSH: begin
            w_rd = ~fifo_empty;
            if (~flush & fifo_empty & ~r_inflight)
               w_state_nx = S_RUN;
         end
         default: ;
      endcase
      w_rd          = w_rd & rst_n;
      w_inflight_nx = w_rd;
      w_valid_nx    = (w_occ_nx != 2'd0);
      w_last_nx     = w_valid_nx & (w_bcnt_nx == LAST);
      w_busy_nx     = w_valid_nx | w_inflight_nx | (w_state_nx == S_FLUSH);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_RUN;
         r_occ      <= 2'd0;
         r_inflight <= 1'b0;
         r_b0       <= '0;
         r_b1       <= '0;
         r_bcnt     <= '0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
         r_busy     <= 1'b0;
         r_words    <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_occ      <= w_occ_nx;
         r_inflight <= w_inflight_nx;
         r_b0       <= w_b0_nx;
         r_b1       <= w_b1_nx;
         r_bcnt     <= w_bcnt_nx;
         r_valid    <= w_valid_nx;
         r_last     <= w_last_nx;
         r_busy     <= w_busy_nx;
         r_words    <= w_words_nx;
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: queue-model FIFOs feed two readers;
// a negedge monitor scores every accepted word against pushed data.
module tb_fifo_stream_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic       en0, fl0, rd0, v0, last0, rdy0, busy0;
   logic       emp0 = 1'b1;
   logic [7:0] rdd0 = 8'h00;
   logic [7:0] d0;
   logic [15:0] wo0;
   logic       we0;
   logic [7:0] wd0;

   logic       en1, fl1, rd1, v1, last1, rdy1, busy1;
   logic       emp1 = 1'b1;
   logic [7:0] rdd1 = 8'h00;
   logic [7:0] d1;
   logic [1:0] wo1;
   logic       we1;
   logic [7:0] wd1;

   logic [7:0] fq0[$], fq1[$], exp0[$], exp1[$];

   int checks = 0, errors = 0;
   int cyc = 0;
   int mb0 = 0, mwords0 = 0, mwords1 = 0;
   int npop = 0, first_pop = -1, last_pop = -1;
   int nrd = 0, t_rd = -1, t_v = -1;
   int vseen = 0, wrapped = 0;
   logic [1:0] wo1_prev = 2'd0;
   logic rnd = 1'b0;

   fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(16)) u0 (
      .clk(clk), .rst_n(rst_n), .enable(en0), .flush(fl0),
      .fifo_rd_en(rd0), .fifo_rd_data(rdd0), .fifo_empty(emp0),
      .m_valid(v0), .m_data(d0), .m_last(last0), .m_ready(rdy0),
      .busy(busy0), .words_out(wo0));

   fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(1), .CNT_WIDTH(2)) u1 (
      .clk(clk), .rst_n(rst_n), .enable(en1), .flush(fl1),
      .fifo_rd_en(rd1), .fifo_rd_data(rdd1), .fifo_empty(emp1),
      .m_valid(v1), .m_data(d1), .m_last(last1), .m_ready(rdy1),
      .busy(busy1), .words_out(wo1));

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input logic [7:0] d);
      we0 = 1'b1; wd0 = d; exp0.push_back(d);
      tick();
      we0 = 1'b0;
   endtask

   task automatic push1(input logic [7:0] d);
      we1 = 1'b1; wd1 = d; exp1.push_back(d);
      tick();
      we1 = 1'b0;
   endtask

   task automatic wait_drain0(input int maxc);
      int n = 0;
      while ((exp0.size() != 0 || busy0) && n < maxc) begin
         tick();
         n++;
      end
      chk("drain0_timeout", (n < maxc) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic clr_track();
      npop = 0; first_pop = -1; last_pop = -1;
      nrd = 0; t_rd = -1; t_v = -1; vseen = 0;
   endtask

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      if (rd0 && fq0.size() != 0) rdd0 <= fq0.pop_front();
      if (we0) fq0.push_back(wd0);
      emp0 <= (fq0.size() == 0);
      if (rd1 && fq1.size() != 0) rdd1 <= fq1.pop_front();
      if (we1) fq1.push_back(wd1);
      emp1 <= (fq1.size() == 0);
   end

   always @(posedge clk) begin
      if (rnd) begin
         #1;
         rdy0 = ($urandom_range(0, 2) != 0);
      end
   end

   always @(negedge clk) begin
      logic [7:0] e;
      if (rst_n) begin
         if (rd0) begin
            nrd++;
            if (t_rd < 0) t_rd = cyc;
            chk("no_rd_when_empty", {31'd0, emp0}, 32'd0);
         end
         if (v0) begin
            vseen = 1;
            if (t_v < 0) t_v = cyc;
         end
         if (v0 && rdy0) begin
            if (exp0.size() == 0) begin
               chk("unexpected_output", {24'd0, d0}, 32'hFFFF_FFFF);
            end else begin
               e = exp0.pop_front();
               chk("data", {24'd0, d0}, {24'd0, e});
               chk("last", {31'd0, last0}, (mb0 == 3) ? 32'd1 : 32'd0);
            end
            mb0 = (mb0 + 1) % 4;
            mwords0++;
            npop++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
         end
         if (fl0) begin
            exp0.delete();
            mb0 = 0;
         end
         if (v1 && rdy1) begin
            if (exp1.size() == 0) begin
               chk("b1_unexpected_output", {24'd0, d1}, 32'hFFFF_FFFF);
            end else begin
               e = exp1.pop_front();
               chk("b1_data", {24'd0, d1}, {24'd0, e});
               chk("b1_last", {31'd0, last1}, 32'd1);
            end
            mwords1++;
         end
         if (wo1_prev == 2'd3 && wo1 == 2'd0) wrapped = 1;
         wo1_prev = wo1;
      end
   end

   initial begin
      int w0;
      rst_n = 1'b0;
      en0 = 0; fl0 = 0; rdy0 = 0; we0 = 0; wd0 = 0;
      en1 = 0; fl1 = 0; rdy1 = 0; we1 = 0; wd1 = 0;
      repeat (3) tick();
      chk("rst_valid", {31'd0, v0}, 0);
      chk("rst_data", {24'd0, d0}, 0);
      chk("rst_last", {31'd0, last0}, 0);
      chk("rst_busy", {31'd0, busy0}, 0);
      chk("rst_words", {16'd0, wo0}, 0);
      chk("rst_rd_en", {31'd0, rd0}, 0);
      chk("rst_last_b1", {31'd0, last1}, 0);
      rst_n = 1'b1;
      tick();

      // T1: 8-word stream, latency and back-to-back beats
      rdy0 = 1;
      for (int i = 0; i < 8; i++) push0(8'h10 + 8'(i));
      repeat (2) tick();
      clr_track();
      en0 = 1;
      wait_drain0(40);
      chk("t1_latency", t_v - t_rd, 2);
      chk("t1_beats", npop, 8);
      chk("t1_no_gaps", last_pop - first_pop, 7);
      chk("t1_words_out", {16'd0, wo0}, 8);
      chk("t1_busy", {31'd0, busy0}, 0);

      // T2: stall holds head, two reads then stop
      rdy0 = 0;
      clr_track();
      for (int i = 0; i < 6; i++) push0(8'h20 + 8'(i));
      repeat (8) tick();
      chk("t2_reads", nrd, 2);
      chk("t2_valid", {31'd0, v0}, 1);
      chk("t2_head", {24'd0, d0}, 32'h20);
      repeat (5) tick();
      chk("t2_head_stable", {24'd0, d0}, 32'h20);
      chk("t2_reads_stable", nrd, 2);
      rdy0 = 1;
      wait_drain0(40);
      chk("t2_beats", npop, 6);
      chk("t2_no_gaps", last_pop - first_pop, 5);

      // T3: single word, then random backpressure over 100 words
      clr_track();
      push0(8'h30);
      repeat (10) tick();
      chk("t3_one_read", nrd, 1);
      wait_drain0(20);
      rnd = 1;
      for (int i = 0; i < 100; i++) begin
         push0(8'($urandom));
         if ($urandom_range(0, 3) == 0) tick();
      end
      rnd = 0;
      tick();
      rdy0 = 1;
      wait_drain0(500);
      chk("t3_words_out", {16'd0, wo0}, 32'(mwords0 & 32'hFFFF));

      // T4: flush after two accepted words
      rdy0 = 0;
      for (int i = 0; i < 5; i++) push0(8'h40 + 8'(i));
      repeat (8) tick();
      w0 = mwords0;
      rdy0 = 1;
      repeat (2) tick();
      rdy0 = 0;
      fl0 = 1;
      tick();
      fl0 = 0;
      chk("t4_valid_drop", {31'd0, v0}, 0);
      chk("t4_busy_flush", {31'd0, busy0}, 1);
      wait_drain0(40);
      chk("t4_fifo_drained", fq0.size(), 0);
      chk("t4_accepted", mwords0 - w0, 2);
      chk("t4_words_out", {16'd0, wo0}, 32'(mwords0 & 32'hFFFF));
      rdy0 = 1;
      for (int i = 0; i < 4; i++) push0(8'h50 + 8'(i));
      wait_drain0(40);

      // T5: enable low holds off reads
      en0 = 0;
      clr_track();
      for (int i = 0; i < 3; i++) push0(8'h70 + 8'(i));
      repeat (10) tick();
      chk("t5_no_reads", nrd, 0);
      chk("t5_no_valid", vseen, 0);
      en0 = 1;
      wait_drain0(40);
      chk("t5_beats", npop, 3);

      // T6: BURST_LEN=1, 2-bit counter
      en1 = 1; rdy1 = 1;
      for (int i = 0; i < 5; i++) push1(8'h80 + 8'(i));
      begin
         int n = 0;
         while ((exp1.size() != 0 || busy1) && n < 40) begin
            tick();
            n++;
         end
         chk("drain1_timeout", (n < 40) ? 32'd1 : 32'd0, 32'd1);
      end
      chk("t6_count", mwords1, 5);
      chk("t6_words_out", {30'd0, wo1}, 1);
      chk("t6_wrapped", wrapped, 1);

      // T7: asynchronous reset mid-burst
      rdy0 = 0;
      for (int i = 0; i < 3; i++) push0(8'h90 + 8'(i));
      repeat (5) tick();
      chk("t7_valid_before", {31'd0, v0}, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t7_valid", {31'd0, v0}, 0);
      chk("t7_data", {24'd0, d0}, 0);
      chk("t7_last", {31'd0, last0}, 0);
      chk("t7_busy", {31'd0, busy0}, 0);
      chk("t7_words", {16'd0, wo0}, 0);
      chk("t7_rd_en", {31'd0, rd0}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
